// File: rtl/button_event_decoder.sv
// +-----------------------------------------------------------------------------+
// | Module      : button_event_decoder                                          |
// | Description : Turns a debounced active-low button level into single-cycle  |
// |               press/release/short/long/repeat pulses plus a held level.     |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
`default_nettype none

module button_event_decoder #(
  parameter int unsigned LONG_CYCLES   = 25_000_000,
  parameter int unsigned REPEAT_CYCLES = 5_000_000,
  parameter bit          REPEAT_EN     = 1'b1,
  parameter int unsigned CNT_W         = 25
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_press,
  output logic long_press,
  output logic repeat_pulse,
  output logic held
);

  localparam logic [CNT_W-1:0] c_LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_WAIT_REL = 2'd0,
    ST_IDLE     = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_LONG     = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_press;
  logic             w_release;
  logic             w_short;
  logic             w_long;
  logic             w_repeat;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_WAIT_REL;
      r_cnt         <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_press   <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      press_pulse   <= w_press;
      release_pulse <= w_release;
      short_press   <= w_short;
      long_press    <= w_long;
      repeat_pulse  <= w_repeat;
      held          <= (w_state_nxt == ST_PRESSED) || (w_state_nxt == ST_LONG);
    end
  end

  // Release is tested before the threshold compare so it always wins.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_press     = 1'b0;
    w_release   = 1'b0;
    w_short     = 1'b0;
    w_long      = 1'b0;
    w_repeat    = 1'b0;
    case (r_state)
      ST_WAIT_REL: begin
        if (btn_n) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      ST_IDLE: begin
        if (!btn_n) begin
          w_state_nxt = ST_PRESSED;
          w_cnt_nxt   = '0;
          w_press     = 1'b1;
        end
      end
      ST_PRESSED: begin
        if (btn_n) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_release   = 1'b1;
          w_short     = 1'b1;
        end else if (r_cnt == c_LONG_LAST) begin
          w_state_nxt = ST_LONG;
          w_cnt_nxt   = '0;
          w_long      = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_LONG: begin
        if (btn_n) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_release   = 1'b1;
        end else if (!REPEAT_EN) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == c_REPEAT_LAST) begin
          w_cnt_nxt = '0;
          w_repeat  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_WAIT_REL;
        w_cnt_nxt   = '0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_button_event_decoder.sv
// +-----------------------------------------------------------------------------+
// | Module      : tb_button_event_decoder                                       |
// | Description : Self-checking bench; two decoders (repeat on/off) against a  |
// |               run-length reference model, directed plus random stimulus.    |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_button_event_decoder;

  localparam int c_LONG   = 8;
  localparam int c_REPEAT = 3;

  logic clk;
  logic reset;
  logic btn_n;
  logic [5:0] w_out [2];

  int n_vec;
  int n_err;

  // Reference state per instance: armed after first release, run = consecutive lows.
  bit r_armed [2];
  int r_run   [2];
  logic [5:0] r_exp [2];

  button_event_decoder #(
    .LONG_CYCLES(c_LONG), .REPEAT_CYCLES(c_REPEAT), .REPEAT_EN(1'b1), .CNT_W(4)
  ) dut_rep (
    .clk(clk), .reset(reset), .btn_n(btn_n),
    .press_pulse(w_out[0][5]), .release_pulse(w_out[0][4]), .short_press(w_out[0][3]),
    .long_press(w_out[0][2]), .repeat_pulse(w_out[0][1]), .held(w_out[0][0])
  );

  button_event_decoder #(
    .LONG_CYCLES(c_LONG), .REPEAT_CYCLES(c_REPEAT), .REPEAT_EN(1'b0), .CNT_W(4)
  ) dut_norep (
    .clk(clk), .reset(reset), .btn_n(btn_n),
    .press_pulse(w_out[1][5]), .release_pulse(w_out[1][4]), .short_press(w_out[1][3]),
    .long_press(w_out[1][2]), .repeat_pulse(w_out[1][1]), .held(w_out[1][0])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
    end
  endtask

  // Outputs derived from the length of the current low run, not from any state encoding.
  task automatic model(input logic rst_v, input logic btn_v);
    for (int i = 0; i < 2; i++) begin
      bit rep_en;
      rep_en   = (i == 0);
      r_exp[i] = '0;
      if (rst_v) begin
        r_armed[i] = 1'b0;
        r_run[i]   = 0;
      end else if (!r_armed[i]) begin
        if (btn_v) r_armed[i] = 1'b1;
      end else if (!btn_v) begin
        r_run[i]++;
        r_exp[i][5] = (r_run[i] == 1);
        r_exp[i][2] = (r_run[i] == c_LONG + 1);
        r_exp[i][1] = rep_en && (r_run[i] > c_LONG + 1) &&
                      ((r_run[i] - (c_LONG + 1)) % c_REPEAT == 0);
        r_exp[i][0] = 1'b1;
      end else if (r_run[i] > 0) begin
        r_exp[i][4] = 1'b1;
        r_exp[i][3] = (r_run[i] <= c_LONG);
        r_run[i]    = 0;
      end
    end
  endtask

  task automatic step(input logic rst_v, input logic btn_v);
    string names [6];
    names = '{"held", "repeat_pulse", "long_press", "short_press", "release_pulse", "press_pulse"};
    reset = rst_v;
    btn_n = btn_v;
    @(posedge clk);
    model(rst_v, btn_v);
    @(negedge clk);
    for (int i = 0; i < 2; i++)
      for (int b = 0; b < 6; b++)
        check($sformatf("%s[rep_en=%0d]", names[b], (i == 0)), w_out[i][b], r_exp[i][b]);
  endtask

  task automatic hold(input logic btn_v, input int n);
    for (int k = 0; k < n; k++) step(1'b0, btn_v);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    btn_n = 1'b1;
    @(negedge clk);
    // reset, idle, short press of 4 cycles
    step(1'b1, 1'b1); step(1'b1, 1'b1);
    hold(1'b1, 3); hold(1'b0, 4); hold(1'b1, 3);
    // long hold with repeats
    hold(1'b0, 20); hold(1'b1, 3);
    // release exactly on the threshold cycle
    hold(1'b0, c_LONG); hold(1'b1, 3);
    // held through reset deassertion
    step(1'b1, 1'b0); step(1'b1, 1'b0);
    hold(1'b0, 5); hold(1'b1, 2); hold(1'b0, 3); hold(1'b1, 2);
    // reset during LONG, then release
    hold(1'b0, 12); step(1'b1, 1'b0); hold(1'b1, 3);
    // long hold (exercises the repeat-disabled instance too)
    hold(1'b0, 30); hold(1'b1, 2);
    // single-cycle lows back to back
    hold(1'b0, 1); hold(1'b1, 1); hold(1'b0, 1); hold(1'b1, 1); hold(1'b0, 1); hold(1'b1, 2);
    // random segments
    for (int s = 0; s < 150; s++) begin
      if ($urandom_range(0, 19) == 0) step(1'b1, 1'($urandom_range(0, 1)));
      hold(1'b0, $urandom_range(1, 24));
      hold(1'b1, $urandom_range(1, 4));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
